// File: rtl/shared_bus_arbiter.sv
// Round-robin owner of the shared L1<->L2 bus: grants one cache bus interface at a time and
// holds the grant until end of transfer, requester abort or watchdog expiry.
module shared_bus_arbiter #(
   parameter int unsigned         NUM_PORTS      = 4,
   parameter int unsigned         MSG_BITS       = 4,
   parameter int unsigned         PORT_BITS      = $clog2(NUM_PORTS),
   parameter int unsigned         TIMEOUT_CYCLES = 64,
   parameter logic [MSG_BITS-1:0] NO_REQ         = '0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_PORTS*MSG_BITS-1:0] port_msg,
   input  logic                          resp_last,
   output logic [NUM_PORTS-1:0]          bus_master,
   output logic                          req_ready,
   output logic [PORT_BITS-1:0]          grant_id,
   output logic                          bus_busy,
   output logic                          timeout_err
);

   // One counter serves as GRANT watchdog and RELEASE dwell timer; it must reach 3 either way.
   localparam int unsigned WdBits = (TIMEOUT_CYCLES > 4) ? $clog2(TIMEOUT_CYCLES) : 2;
   localparam logic [WdBits-1:0] WdLast  = WdBits'(TIMEOUT_CYCLES - 1);
   localparam logic [WdBits-1:0] RelLast = WdBits'(3);

   typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

   state_e                 state_q, state_d;
   logic [WdBits-1:0]      wd_q, wd_d;
   logic [PORT_BITS-1:0]   grant_id_q, grant_id_d;
   logic [NUM_PORTS-1:0]   bus_master_q, bus_master_d;
   logic                   req_ready_q, req_ready_d;
   logic                   bus_busy_q, bus_busy_d;
   logic                   timeout_err_q, timeout_err_d;

   logic [NUM_PORTS-1:0]   req;
   logic [PORT_BITS-1:0]   sel;
   logic [PORT_BITS-1:0]   idx;
   logic                   sel_vld;
   logic                   owner_req;

   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         req[i] = (port_msg[i*MSG_BITS +: MSG_BITS] != NO_REQ);
      end
   end

   assign owner_req = req[grant_id_q];

   // grant_id_q doubles as the round-robin pointer: both change only on a grant.
   always_comb begin
      sel     = grant_id_q;
      sel_vld = 1'b0;
      idx     = '0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         idx = PORT_BITS'((32'(grant_id_q) + k) % NUM_PORTS);
         if (!sel_vld && req[idx]) begin
            sel_vld = 1'b1;
            sel     = idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         wd_q          <= '0;
         grant_id_q    <= PORT_BITS'(NUM_PORTS - 1);
         bus_master_q  <= '0;
         req_ready_q   <= 1'b0;
         bus_busy_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wd_q          <= wd_d;
         grant_id_q    <= grant_id_d;
         bus_master_q  <= bus_master_d;
         req_ready_q   <= req_ready_d;
         bus_busy_q    <= bus_busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      grant_id_d = grant_id_q;
      unique case (state_q)
         StIdle: begin
            if (sel_vld) begin
               state_d    = StGrant;
               grant_id_d = sel;
               wd_d       = '0;
            end
         end
         StGrant: begin
            if (resp_last || !owner_req || (wd_q == WdLast)) begin
               state_d = StRelease;
               wd_d    = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         StRelease: begin
            // Capped dwell so a requester still holding its old message cannot stall the bus.
            if (!owner_req || (wd_q == RelLast)) begin
               state_d = StIdle;
               wd_d    = '0;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            wd_d    = '0;
         end
      endcase
   end

   always_comb begin
      bus_master_d = '0;
      if (state_d == StGrant) begin
         bus_master_d[grant_id_d] = 1'b1;
      end
      req_ready_d   = (state_d == StGrant);
      bus_busy_d    = (state_d != StIdle);
      // Completion and abort take precedence over an expiring watchdog.
      timeout_err_d = (state_q == StGrant) && !resp_last && owner_req && (wd_q == WdLast);
   end

   assign bus_master  = bus_master_q;
   assign req_ready   = req_ready_q;
   assign grant_id    = grant_id_q;
   assign bus_busy    = bus_busy_q;
   assign timeout_err = timeout_err_q;

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (!reset) begin
         assert ($onehot0(bus_master_q));
         assert (req_ready_q == (|bus_master_q));
         assert (bus_busy_q == (state_q != StIdle));
      end
   end
`endif

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: reset, single grant, round-robin order, watchdog,
// abort and reset during a grant, each with hand-computed expectations.
module tb_shared_bus_arbiter;

   localparam logic [3:0] NoReq = 4'h0;
   localparam logic [3:0] RReq  = 4'h1;
   localparam logic [3:0] WbReq = 4'h2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] port_msg = '0;
   logic        resp_last = 1'b0;
   logic [3:0]  bus_master;
   logic        req_ready;
   logic [1:0]  grant_id;
   logic        bus_busy;
   logic        timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   shared_bus_arbiter #(
      .NUM_PORTS      (4),
      .MSG_BITS       (4),
      .PORT_BITS      (2),
      .TIMEOUT_CYCLES (64),
      .NO_REQ         (4'h0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .port_msg    (port_msg),
      .resp_last   (resp_last),
      .bus_master  (bus_master),
      .req_ready   (req_ready),
      .grant_id    (grant_id),
      .bus_busy    (bus_busy),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_msg(input int p, input logic [3:0] m);
      port_msg[p*4 +: 4] = m;
   endtask

   task automatic wait_grant(input int bound, output int n);
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         tick();
         if (req_ready === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      port_msg  = '0;
      resp_last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if ({bus_master, req_ready, grant_id, bus_busy, timeout_err} !== 9'b0000_0_11_0_0) begin
            $display("FAIL reset_idle cyc %0d: got bm=%b rdy=%b gid=%0d busy=%b to=%b, want 0/0/3/0/0",
                     i, bus_master, req_ready, grant_id, bus_busy, timeout_err);
            n_fail++;
         end
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if ({bus_master, req_ready, grant_id, bus_busy, timeout_err} !== 9'b0000_0_11_0_0) begin
         $display("FAIL post_reset_idle: got bm=%b rdy=%b gid=%0d busy=%b, want 0/0/3/0",
                  bus_master, req_ready, grant_id, bus_busy);
         n_fail++;
      end
   endtask

   task automatic test_single_wb();
      set_msg(2, WbReq);
      tick();
      n_checks++;
      if ({bus_master, req_ready, grant_id, bus_busy, timeout_err} !== 9'b0100_1_10_1_0) begin
         $display("FAIL single_grant: got bm=%b rdy=%b gid=%0d busy=%b to=%b, want 0100/1/2/1/0",
                  bus_master, req_ready, grant_id, bus_busy, timeout_err);
         n_fail++;
      end
      repeat (3) tick();
      n_checks++;
      if ({bus_master, req_ready, grant_id} !== 7'b0100_1_10) begin
         $display("FAIL single_hold: got bm=%b rdy=%b gid=%0d, want 0100/1/2",
                  bus_master, req_ready, grant_id);
         n_fail++;
      end
      resp_last = 1'b1;
      tick();
      resp_last = 1'b0;
      n_checks++;
      if ({bus_master, req_ready, bus_busy, timeout_err} !== 7'b0000_0_1_0) begin
         $display("FAIL single_release: got bm=%b rdy=%b busy=%b to=%b, want 0000/0/1/0",
                  bus_master, req_ready, bus_busy, timeout_err);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({bus_master, bus_busy} !== 5'b0000_1) begin
         $display("FAIL single_stale_hold: got bm=%b busy=%b, want 0000/1", bus_master, bus_busy);
         n_fail++;
      end
      set_msg(2, NoReq);
      tick();
      n_checks++;
      if ({bus_master, req_ready, grant_id, bus_busy, timeout_err} !== 9'b0000_0_10_0_0) begin
         $display("FAIL single_idle: got bm=%b rdy=%b gid=%0d busy=%b, want 0000/0/2/0",
                  bus_master, req_ready, grant_id, bus_busy);
         n_fail++;
      end
   endtask

   task automatic test_round_robin();
      int         order [6] = '{0, 1, 3, 0, 1, 3};
      int         waited;
      logic       got;
      logic [3:0] exp_bm;
      reset = 1'b1;
      port_msg = '0;
      tick();
      reset = 1'b0;
      set_msg(0, RReq);
      set_msg(1, RReq);
      set_msg(3, RReq);
      for (int k = 0; k < 6; k++) begin
         waited = 0;
         got    = 1'b0;
         while (!got && waited < 20) begin
            tick();
            waited++;
            n_checks++;
            if ($countones(bus_master) > 1) begin
               $display("FAIL rr_onehot: got bm=%b, want at most one bit", bus_master);
               n_fail++;
            end
            if (req_ready === 1'b1) got = 1'b1;
         end
         n_checks++;
         if (!got || grant_id !== 2'(order[k])) begin
            $display("FAIL rr_order grant %0d: got gid=%0d rdy=%b, want gid=%0d",
                     k, grant_id, req_ready, order[k]);
            n_fail++;
         end
         n_checks++;
         if (waited !== ((k == 0) ? 1 : 5)) begin
            $display("FAIL rr_gap grant %0d: got %0d cycles, want %0d",
                     k, waited, (k == 0) ? 1 : 5);
            n_fail++;
         end
         tick();
         tick();
         exp_bm = 4'(1 << order[k]);
         n_checks++;
         if (bus_master !== exp_bm) begin
            $display("FAIL rr_hold grant %0d: got bm=%b, want %b", k, bus_master, exp_bm);
            n_fail++;
         end
         resp_last = 1'b1;
         tick();
         resp_last = 1'b0;
         n_checks++;
         if (bus_master !== 4'b0000) begin
            $display("FAIL rr_release grant %0d: got bm=%b, want 0000", k, bus_master);
            n_fail++;
         end
      end
      port_msg = '0;
      tick();
      tick();
   endtask

   task automatic test_timeout();
      int held;
      int n;
      int exp_id [3] = '{3, 0, 1};
      int exp_n  [3] = '{4, 5, 5};
      set_msg(1, RReq);
      tick();
      n_checks++;
      if ({bus_master, grant_id} !== 6'b0010_01) begin
         $display("FAIL to_grant: got bm=%b gid=%0d, want 0010/1", bus_master, grant_id);
         n_fail++;
      end
      set_msg(0, RReq);
      set_msg(3, RReq);
      held = 0;
      for (int i = 0; i < 63; i++) begin
         tick();
         if (bus_master === 4'b0010 && timeout_err === 1'b0) held++;
      end
      n_checks++;
      if (held !== 63) begin
         $display("FAIL to_hold: got %0d held cycles after grant, want 63", held);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({bus_master, req_ready, bus_busy, timeout_err} !== 7'b0000_0_1_1) begin
         $display("FAIL to_release: got bm=%b rdy=%b busy=%b to=%b, want 0000/0/1/1",
                  bus_master, req_ready, bus_busy, timeout_err);
         n_fail++;
      end
      tick();
      n_checks++;
      if ({bus_master, timeout_err} !== 5'b0000_0) begin
         $display("FAIL to_pulse: got bm=%b to=%b, want 0000/0", bus_master, timeout_err);
         n_fail++;
      end
      for (int k = 0; k < 3; k++) begin
         wait_grant(20, n);
         n_checks++;
         if (n !== exp_n[k] || grant_id !== 2'(exp_id[k])) begin
            $display("FAIL to_regrant %0d: got gid=%0d after %0d cycles, want gid=%0d after %0d",
                     k, grant_id, n, exp_id[k], exp_n[k]);
            n_fail++;
         end
         resp_last = 1'b1;
         tick();
         resp_last = 1'b0;
      end
      port_msg = '0;
      tick();
      tick();
   endtask

   task automatic test_timeout_vs_resp();
      set_msg(2, WbReq);
      tick();
      n_checks++;
      if ({bus_master, grant_id} !== 6'b0100_10) begin
         $display("FAIL tie_grant: got bm=%b gid=%0d, want 0100/2", bus_master, grant_id);
         n_fail++;
      end
      repeat (63) tick();
      n_checks++;
      if (bus_master !== 4'b0100) begin
         $display("FAIL tie_hold: got bm=%b, want 0100", bus_master);
         n_fail++;
      end
      resp_last = 1'b1;
      tick();
      resp_last = 1'b0;
      n_checks++;
      if ({bus_master, bus_busy, timeout_err} !== 6'b0000_1_0) begin
         $display("FAIL tie_no_timeout: got bm=%b busy=%b to=%b, want 0000/1/0",
                  bus_master, bus_busy, timeout_err);
         n_fail++;
      end
      set_msg(2, NoReq);
      tick();
   endtask

   task automatic test_abort();
      int n;
      set_msg(0, RReq);
      tick();
      n_checks++;
      if ({bus_master, grant_id} !== 6'b0001_00) begin
         $display("FAIL abort_grant: got bm=%b gid=%0d, want 0001/0", bus_master, grant_id);
         n_fail++;
      end
      set_msg(3, RReq);
      tick();
      tick();
      set_msg(0, NoReq);
      tick();
      n_checks++;
      if ({bus_master, req_ready, bus_busy, timeout_err} !== 7'b0000_0_1_0) begin
         $display("FAIL abort_drop: got bm=%b rdy=%b busy=%b to=%b, want 0000/0/1/0",
                  bus_master, req_ready, bus_busy, timeout_err);
         n_fail++;
      end
      wait_grant(10, n);
      n_checks++;
      if (n !== 2 || grant_id !== 2'd3 || bus_master !== 4'b1000) begin
         $display("FAIL abort_next: got gid=%0d bm=%b after %0d cycles, want 3/1000 after 2",
                  grant_id, bus_master, n);
         n_fail++;
      end
      set_msg(3, NoReq);
      tick();
      tick();
   endtask

   task automatic test_reset_mid_grant();
      set_msg(2, WbReq);
      tick();
      n_checks++;
      if ({bus_master, grant_id} !== 6'b0100_10) begin
         $display("FAIL rst_grant: got bm=%b gid=%0d, want 0100/2", bus_master, grant_id);
         n_fail++;
      end
      tick();
      tick();
      reset = 1'b1;
      set_msg(0, RReq);
      tick();
      n_checks++;
      if ({bus_master, req_ready, grant_id, bus_busy, timeout_err} !== 9'b0000_0_11_0_0) begin
         $display("FAIL rst_drop: got bm=%b rdy=%b gid=%0d busy=%b, want 0000/0/3/0",
                  bus_master, req_ready, grant_id, bus_busy);
         n_fail++;
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if ({bus_master, req_ready, grant_id} !== 7'b0001_1_00) begin
         $display("FAIL rst_tie: got bm=%b rdy=%b gid=%0d, want 0001/1/0",
                  bus_master, req_ready, grant_id);
         n_fail++;
      end
   endtask

   initial begin
      test_reset();
      test_single_wb();
      test_round_robin();
      test_timeout();
      test_timeout_vs_resp();
      test_abort();
      test_reset_mid_grant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_watchdog: got no completion by 200000, want finish earlier");
      $fatal(1, "simulation time limit");
   end

endmodule
